sorted_vector_unloader: RTL and testbench
=========================================

// Module: sorted_vector_unloader
// PURPOSE
// - Consumer end of the parallel sorter. Accepts one sorted N-lane vector (lane 0 = smallest) per handshake.
// - Serialises the vector to a DW-wide valid/ready stream, one element per beat, ascending or descending.
// - Two-slot (active + pending) buffering so back-to-back vectors stream without bubbles.
// - Sits between the parallel sorter output and narrow downstream logic (FIFO, UART, memory writer).
// PARAMETERS
// - N   4  lanes per vector; N>=1
// - DW  8  bits per element
// - IW  (N>1 ? $clog2(N) : 1)  index width; localparam, not overridable
// PORTS
// - clk        in   1     rising-edge clock, single clock domain
// - rst        in   1     synchronous, active-high reset
// - in_vec     in   DW*N  sorted vector; lane r = in_vec[DW*(r+1)-1:DW*r]
// - in_dir     in   1     0 = ascending (lane 0 first), 1 = descending (lane N-1 first); sampled with in_vec
// - in_valid   in   1     in_vec/in_dir valid
// - in_ready   out  1     block can accept a vector this cycle
// - out_data   out  DW    current element
// - out_idx    out  IW    beat number within vector, 0..N-1 (not lane number)
// - out_first  out  1     out_idx==0
// - out_last   out  1     out_idx==N-1
// - out_valid  out  1     out_* valid
// - out_ready  in   1     downstream accepts beat
// - busy       out  1     any slot occupied
// BEHAVIOUR
// - Reset: act_v=pend_v=0, cnt=0, both buffers and dir flags cleared; out_valid=0, out_data=0, out_idx=0,
//   out_first=0, out_last=0 (all gated by act_v), busy=0, in_ready=1 in the first cycle after reset.
// - Reset mid-vector discards both slots; no partial beats are emitted after reset deasserts.
// - Handshakes: in_acc = in_valid & in_ready; out_acc = out_valid & out_ready; done = out_acc & out_last.
// - in_ready = ~pend_v (combinational from state only, never from in_valid or out_ready).
// - Accept routing on in_acc:
//   - if ~act_v, or done & ~pend_v: load the active slot, act_v=1, cnt=0.
//   - else: load the pending slot, pend_v=1.
// - On done with pend_v=1: pending moves to active, pend_v=0, cnt=0.
//   - A simultaneous in_acc cannot occur, since in_ready=0.
// - On done with no pending and no in_acc: act_v=0.
// - On out_acc & ~out_last: cnt=cnt+1.
// - Lane select: lane = dir_act ? N-1-cnt : cnt; out_data = act_buf[lane]; out_idx = cnt.
// - Latency: vector accepted in cycle t -> first beat valid in cycle t+1.
//   - Steady state N beats per vector, zero bubbles when out_ready is held high.
// - AXI-style stability: while out_valid & ~out_ready, out_data/out_idx/out_first/out_last hold constant.
//   - Pending-slot loads never disturb the active slot.
// - out_valid = act_v; busy = act_v | pend_v.
// - N=1: every beat has out_first=out_last=1; cnt stays 0.
// - Data is passed through unchecked; sortedness of in_vec is the producer's responsibility.
// STRUCTURE
// - Shared package sorter_pkg:
//   - DIR_ASC=1'b0, DIR_DESC=1'b1.
//   - Default N and DW, shared with the parallel sorter so both ends agree.
// - One natural sub-module: sorted_vector_slot.
//   - DW*N data register + dir bit + valid flag, with load and clear controls.
//   - Instantiated twice (active, pending).
//   - Active-to-pending move is a parallel copy in the top level.
// - Control: counter plus two valid flags; no explicit FSM encoding beyond {act_v,pend_v} = EMPTY/ONE/TWO.
// TESTING (N=4, DW=8)
// - Single ascending vector: in_vec={8'h40,8'h30,8'h20,8'h10}, dir=0, out_ready=1.
//   - Expect out_data 10,20,30,40 in cycles t+1..t+4.
//   - out_first on the 10 beat, out_last on the 40 beat.
// - Same vector, dir=1 -> 40,30,20,10 with out_idx 0,1,2,3.
// - Back-to-back: vectors A, B, C offered continuously, out_ready=1.
//   - Expect 12 contiguous beats with no gap.
//   - in_ready drops while both slots are full.
//   - C is accepted on the cycle A's last beat completes +1.
// - Backpressure: out_ready=0 for 5 cycles at beat 2.
//   - out_data=30 and out_idx=2 held stable; no beat lost or duplicated.
// - Reset mid-operation: rst=1 during beat 1 with a pending vector queued.
//   - Next cycle: out_valid=0, busy=0, in_ready=1.
//   - A new vector then streams from its lane 0.
// - Random stimulus vs scoreboard: random in_valid/out_ready, random dir, 1000 vectors.
//   - Every beat matches expected order; vector count conserved.

Source files
------------

// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared sorter constants and direction encoding
package sorter_pkg;

  // Default geometry, shared with the parallel sorter so both ends agree.
  localparam int SORT_N  = 4;
  localparam int SORT_DW = 8;

  // Serialisation direction for a sorted vector.
  typedef enum logic {
    DIR_ASC  = 1'b0,
    DIR_DESC = 1'b1
  } sort_dir_e;

endpackage

// File: rtl/sorted_vector_slot.sv
// rtl/sorted_vector_slot.sv - one buffered sorted vector with its direction and valid flag
module sorted_vector_slot
  import sorter_pkg::*;
#(
  parameter int N  = SORT_N,
  parameter int DW = SORT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [DW*N-1:0] i_vec,
  input  logic          i_dir,
  output logic [DW*N-1:0] o_vec,
  output logic          o_dir,
  output logic          o_valid
);

  logic [DW*N-1:0] r_vec;
  logic            r_dir;
  logic            r_valid;

  // Load wins over clear so a slot can be refilled in the same cycle it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec   <= '0;
      r_dir   <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_vec   <= i_vec;
      r_dir   <= i_dir;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_vec   = r_vec;
  assign o_dir   = r_dir;
  assign o_valid = r_valid;

endmodule

// File: rtl/sorted_vector_unloader.sv
// rtl/sorted_vector_unloader.sv - serialises sorted N-lane vectors to a one-element-per-beat stream
module sorted_vector_unloader
  import sorter_pkg::*;
#(
  parameter  int N  = SORT_N,
  parameter  int DW = SORT_DW,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW*N-1:0] in_vec,
  input  logic            in_dir,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_first,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  logic [DW*N-1:0] w_act_vec;
  logic [DW*N-1:0] w_pend_vec;
  logic [DW*N-1:0] w_act_load_vec;
  logic            w_act_dir;
  logic            w_pend_dir;
  logic            w_act_load_dir;
  logic            w_act_v;
  logic            w_pend_v;

  logic            w_in_ready;
  logic            w_in_acc;
  logic            w_out_acc;
  logic            w_last;
  logic            w_done;
  logic            w_load_act_in;
  logic            w_load_pend;
  logic            w_promote;
  logic            w_act_load;

  logic [IW-1:0]   r_cnt;
  logic [IW-1:0]   w_lane;
  logic [DW-1:0]   w_lane_data;

  // Handshakes. in_ready depends on state only so no combinational path from in_valid/out_ready.
  assign w_in_ready = ~w_pend_v;
  assign w_in_acc   = in_valid & w_in_ready;
  assign w_out_acc  = w_act_v & out_ready;
  assign w_last     = (r_cnt == IW'(N - 1));
  assign w_done     = w_out_acc & w_last;

  // Slot routing: an incoming vector goes straight to active when active is free (or frees
  // this cycle with nothing waiting); otherwise it waits in pending.
  assign w_load_act_in = w_in_acc & (~w_act_v | (w_done & ~w_pend_v));
  assign w_load_pend   = w_in_acc & ~w_load_act_in;
  assign w_promote     = w_done & w_pend_v;
  assign w_act_load    = w_load_act_in | w_promote;

  assign w_act_load_vec = w_promote ? w_pend_vec : in_vec;
  assign w_act_load_dir = w_promote ? w_pend_dir : in_dir;

  sorted_vector_slot #(
    .N  (N),
    .DW (DW)
  ) u_act_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_act_load),
    .i_clear (w_done),
    .i_vec   (w_act_load_vec),
    .i_dir   (w_act_load_dir),
    .o_vec   (w_act_vec),
    .o_dir   (w_act_dir),
    .o_valid (w_act_v)
  );

  sorted_vector_slot #(
    .N  (N),
    .DW (DW)
  ) u_pend_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_pend),
    .i_clear (w_promote),
    .i_vec   (in_vec),
    .i_dir   (in_dir),
    .o_vec   (w_pend_vec),
    .o_dir   (w_pend_dir),
    .o_valid (w_pend_v)
  );

  // Beat counter: restarts whenever a new vector enters the active slot, advances per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_act_load) begin
      r_cnt <= '0;
    end else if (w_out_acc && !w_last) begin
      r_cnt <= r_cnt + IW'(1);
    end
  end

  // Map beat number to lane: descending vectors are read from the top lane down.
  always_comb begin
    w_lane = r_cnt;
    if (w_act_dir == DIR_DESC) begin
      w_lane = IW'(N - 1) - r_cnt;
    end
  end

  // Lane multiplexer over the active buffer.
  always_comb begin
    w_lane_data = '0;
    for (int r = 0; r < N; r++) begin
      if (w_lane == IW'(r)) begin
        w_lane_data = w_act_vec[DW*r +: DW];
      end
    end
  end

  // Stream outputs are zeroed whenever no vector is active.
  always_comb begin
    out_valid = w_act_v;
    out_data  = '0;
    out_idx   = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    if (w_act_v) begin
      out_data  = w_lane_data;
      out_idx   = r_cnt;
      out_first = (r_cnt == '0);
      out_last  = w_last;
    end
  end

  assign in_ready = w_in_ready;
  assign busy     = w_act_v | w_pend_v;

endmodule

// File: tb/tb_sorted_vector_unloader.sv
// tb/tb_sorted_vector_unloader.sv - self-checking bench for sorted_vector_unloader
module tb_sorted_vector_unloader;

  logic        clk;
  logic        rst;
  logic [31:0] in_vec;
  logic        in_dir;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_first;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  sorted_vector_unloader #(
    .N  (4),
    .DW (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_dir    (in_dir),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    expect_eq({tag, "_out_valid"}, out_valid, 0);
    expect_eq({tag, "_busy"},      busy,      0);
    expect_eq({tag, "_in_ready"},  in_ready,  1);
    expect_eq({tag, "_out_data"},  out_data,  0);
    expect_eq({tag, "_out_idx"},   out_idx,   0);
    expect_eq({tag, "_out_first"}, out_first, 0);
    expect_eq({tag, "_out_last"},  out_last,  0);
  endtask

  task automatic check_beat(input string tag, input logic [7:0] data, input int k);
    expect_eq({tag, "_valid"}, out_valid, 1);
    expect_eq({tag, "_data"},  out_data,  data);
    expect_eq({tag, "_idx"},   out_idx,   k);
    expect_eq({tag, "_first"}, out_first, (k == 0));
    expect_eq({tag, "_last"},  out_last,  (k == 3));
  endtask

  // exp_seq holds the expected beats, beat k in bits [8k+7:8k].
  task automatic run_single(input string tag, input logic [31:0] vec, input logic dir,
                            input logic [31:0] exp_seq);
    in_vec    = vec;
    in_dir    = dir;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    expect_eq({tag, "_accept_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_beat(tag, exp_seq[8*k +: 8], k);
      step();
    end
    expect_eq({tag, "_end_valid"}, out_valid, 0);
    expect_eq({tag, "_end_busy"},  busy,      0);
  endtask

  logic [31:0] b2b_vec [3];
  logic        b2b_dir [3];
  logic [7:0]  b2b_exp [12];
  logic [7:0]  stall_exp [4];
  logic [7:0]  rnd_q [$];
  logic [31:0] tmp_vec;
  logic [7:0]  exp_byte;

  initial begin
    int s;
    logic acc;
    int sent;
    int recv;
    int beats;
    int cyc;
    logic ia;
    logic oa;

    rst       = 1'b1;
    in_vec    = '0;
    in_dir    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_idle("reset_held");
    rst = 1'b0;
    step();
    check_idle("reset_released");

    run_single("asc",  32'h40302010, 1'b0, 32'h40302010);
    run_single("desc", 32'h40302010, 1'b1, 32'h10203040);

    // Back-to-back A, B, C with out_ready held high.
    b2b_vec[0] = 32'h40302010; b2b_dir[0] = 1'b0;
    b2b_vec[1] = 32'h88776655; b2b_dir[1] = 1'b1;
    b2b_vec[2] = 32'h0d0c0b0a; b2b_dir[2] = 1'b0;
    b2b_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h88, 8'h77, 8'h66, 8'h55,
                8'h0a, 8'h0b, 8'h0c, 8'h0d};
    out_ready = 1'b1;
    in_vec    = b2b_vec[0];
    in_dir    = b2b_dir[0];
    in_valid  = 1'b1;
    s = 0;
    acc = in_valid & in_ready;
    step();
    if (acc) s++;
    for (int i = 0; i < 12; i++) begin
      expect_eq("b2b_valid", out_valid, 1);
      expect_eq("b2b_data",  out_data,  b2b_exp[i]);
      expect_eq("b2b_idx",   out_idx,   i % 4);
      expect_eq("b2b_in_ready", in_ready, (i == 0 || i == 4 || i >= 8));
      if (s < 3) begin
        in_vec   = b2b_vec[s];
        in_dir   = b2b_dir[s];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid & in_ready;
      step();
      if (acc) s++;
    end
    in_valid = 1'b0;
    expect_eq("b2b_accepted", s, 3);
    expect_eq("b2b_end_valid", out_valid, 0);
    expect_eq("b2b_end_busy",  busy,      0);

    // Backpressure at beat 2 while a second vector lands in the pending slot.
    in_vec    = 32'h40302010;
    in_dir    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("bp_b0", 8'h10, 0);
    step();
    check_beat("bp_b1", 8'h20, 1);
    step();
    out_ready = 1'b0;
    in_vec    = 32'h04030201;
    in_dir    = 1'b1;
    in_valid  = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check_beat("bp_hold", 8'h30, 2);
      if (j == 0) expect_eq("bp_pend_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
    end
    check_beat("bp_hold_end", 8'h30, 2);
    expect_eq("bp_full_ready", in_ready, 0);
    expect_eq("bp_busy", busy, 1);
    out_ready = 1'b1;
    step();
    check_beat("bp_b3", 8'h40, 3);
    step();
    stall_exp = '{8'h04, 8'h03, 8'h02, 8'h01};
    for (int k = 0; k < 4; k++) begin
      check_beat("bp_next", stall_exp[k], k);
      step();
    end
    expect_eq("bp_end_valid", out_valid, 0);

    // Reset during beat 1 with a pending vector queued.
    in_vec    = 32'h40302010;
    in_dir    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_vec = 32'h88776655;
    in_dir = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("rst_pre", 8'h20, 1);
    expect_eq("rst_pre_pend", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_eq("rst_mid_valid",    out_valid, 0);
    expect_eq("rst_mid_busy",     busy,      0);
    expect_eq("rst_mid_in_ready", in_ready,  1);
    in_vec   = 32'h44332211;
    in_dir   = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_beat("rst_new_b0", 8'h11, 0);
    for (int k = 0; k < 4; k++) step();
    expect_eq("rst_new_drained", out_valid, 0);
    expect_eq("rst_new_busy",    busy,      0);

    // Random traffic against a scoreboard.
    sent = 0; recv = 0; beats = 0; cyc = 0;
    in_valid = 1'b0;
    while (recv < 1000 && cyc < 60000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 9) < 7) begin
        in_vec   = $urandom;
        in_dir   = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      ia = in_valid & in_ready;
      oa = out_valid & out_ready;
      if (oa) begin
        if (rnd_q.size() == 0) begin
          expect_eq("rnd_underflow", 1, 0);
        end else begin
          exp_byte = rnd_q.pop_front();
          expect_eq("rnd_data", out_data, exp_byte);
        end
        expect_eq("rnd_idx",  out_idx,  beats % 4);
        expect_eq("rnd_last", out_last, ((beats % 4) == 3));
        beats++;
        if (beats % 4 == 0) recv++;
      end
      if (ia) begin
        tmp_vec = in_vec;
        for (int k = 0; k < 4; k++) begin
          rnd_q.push_back(in_dir ? tmp_vec[8*(3-k) +: 8] : tmp_vec[8*k +: 8]);
        end
      end
      step();
      cyc++;
      if (ia) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    expect_eq("rnd_vectors_out", recv, 1000);
    expect_eq("rnd_vectors_in",  sent, 1000);
    expect_eq("rnd_queue_empty", rnd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
